// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : Free-running down counter that reloads TOP_VALUE after zero,
//               with a zero flag and a one-cycle registered reload pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] TOP_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] counter,
    output logic             zero,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_counter;
    logic             r_wrap;
    logic             w_zero;

    assign w_zero = (r_counter == '0);

    // Zero is replaced by TOP_VALUE, so the decrement can never underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_counter <= TOP_VALUE;
            r_wrap    <= 1'b0;
        end else if (w_zero) begin
            r_counter <= TOP_VALUE;
            r_wrap    <= 1'b1;
        end else begin
            r_counter <= r_counter - c_one;
            r_wrap    <= 1'b0;
        end
    end

    assign counter = r_counter;
    assign zero    = w_zero;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter
// Description : Self-checking bench for down_counter in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] c0, c1;
    logic [7:0] c2;
    logic       z0, z1, z2, w0, w1, w2;

    int passed = 0;
    int total  = 0;

    // Reference: edges seen since the last reset release.
    longint n = 0;

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
        logic       zero;
        logic       wrap;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    down_counter #(.WIDTH(4)) dut0 (
        .clk(clk), .reset(reset), .counter(c0), .zero(z0), .wrap(w0)
    );
    down_counter #(.WIDTH(4), .TOP_VALUE(4'd9)) dut1 (
        .clk(clk), .reset(reset), .counter(c1), .zero(z1), .wrap(w1)
    );
    down_counter #(.WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .counter(c2), .zero(z2), .wrap(w2)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    function automatic logic [31:0] ecnt(longint top);
        return 32'(top - (n % (top + 1)));
    endfunction

    function automatic logic [31:0] ezero(longint top);
        return {31'b0, (ecnt(top) == 32'd0)};
    endfunction

    function automatic logic [31:0] ewrap(longint top);
        return {31'b0, (n != 0 && (n % (top + 1)) == 0)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic check_all(string tag);
        chk({tag, " cnt0"},  {28'b0, c0}, ecnt(15));
        chk({tag, " zero0"}, {31'b0, z0}, ezero(15));
        chk({tag, " wrap0"}, {31'b0, w0}, ewrap(15));
        chk({tag, " cnt1"},  {28'b0, c1}, ecnt(9));
        chk({tag, " zero1"}, {31'b0, z1}, ezero(9));
        chk({tag, " wrap1"}, {31'b0, w1}, ewrap(9));
        chk({tag, " cnt2"},  {24'b0, c2}, ecnt(255));
        chk({tag, " zero2"}, {31'b0, z2}, ezero(255));
        chk({tag, " wrap2"}, {31'b0, w2}, ewrap(255));
    endtask

    initial begin
        int  last0, last1, last2;
        bit  found;

        vecs = '{
            '{1'b1, 4'd14, 1'b0, 1'b0}, '{1'b1, 4'd13, 1'b0, 1'b0},
            '{1'b1, 4'd12, 1'b0, 1'b0}, '{1'b1, 4'd11, 1'b0, 1'b0},
            '{1'b1, 4'd10, 1'b0, 1'b0}, '{1'b1, 4'd9,  1'b0, 1'b0},
            '{1'b1, 4'd8,  1'b0, 1'b0}, '{1'b1, 4'd7,  1'b0, 1'b0},
            '{1'b1, 4'd6,  1'b0, 1'b0}, '{1'b1, 4'd5,  1'b0, 1'b0},
            '{1'b1, 4'd4,  1'b0, 1'b0}, '{1'b1, 4'd3,  1'b0, 1'b0},
            '{1'b1, 4'd2,  1'b0, 1'b0}, '{1'b1, 4'd1,  1'b0, 1'b0},
            '{1'b1, 4'd0,  1'b1, 1'b0}, '{1'b1, 4'd15, 1'b0, 1'b1},
            '{1'b1, 4'd14, 1'b0, 1'b0}
        };

        // Reset hold: asynchronous effect before any clock edge, then held.
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("async reset cnt0", {28'b0, c0}, 32'd15);
        chk("async reset cnt2", {24'b0, c2}, 32'd255);
        check_all("hold t2");
        repeat (2) begin
            @(posedge clk); #1;
            chk("hold cnt0", {28'b0, c0}, 32'd15);
            chk("hold zero0", {31'b0, z0}, 32'd0);
            chk("hold wrap0", {31'b0, w0}, 32'd0);
            check_all("hold");
        end

        // Table: release at t=20, then count down through the first reload.
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            @(posedge clk); #1;
            chk($sformatf("vec%0d cnt", i),  {28'b0, c0}, {28'b0, vecs[i].cnt});
            chk($sformatf("vec%0d zero", i), {31'b0, z0}, {31'b0, vecs[i].zero});
            chk($sformatf("vec%0d wrap", i), {31'b0, w0}, {31'b0, vecs[i].wrap});
            check_all("vec");
        end

        // Free run: several periods of each configuration, wrap spacing measured.
        last0 = -1; last1 = -1; last2 = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            check_all("run");
            if (c1 == 4'd15) chk("dut1 shows 15", {28'b0, c1}, 32'd9);
            if (w0) begin
                if (last0 >= 0) chk("period0", 32'(cyc - last0), 32'd16);
                last0 = cyc;
            end
            if (w1) begin
                if (last1 >= 0) chk("period1", 32'(cyc - last1), 32'd10);
                last1 = cyc;
            end
            if (w2) begin
                if (last2 >= 0) chk("period2", 32'(cyc - last2), 32'd256);
                last2 = cyc;
            end
        end

        // Mid-count asynchronous reset at counter == 7.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (c0 == 4'd7) found = 1'b1;
        end
        chk("reach 7", {31'b0, found}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("midreset cnt0", {28'b0, c0}, 32'd15);
        chk("midreset wrap0", {31'b0, w0}, 32'd0);
        check_all("midreset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("after midreset cnt0", {28'b0, c0}, 32'd14);
        chk("after midreset wrap0", {31'b0, w0}, 32'd0);
        check_all("after midreset");

        // Reset while wrap is high drops it at once.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (w0) found = 1'b1;
        end
        chk("reach wrap", {31'b0, found}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("wrapreset wrap0", {31'b0, w0}, 32'd0);
        chk("wrapreset cnt0", {28'b0, c0}, 32'd15);
        check_all("wrapreset");
        @(negedge clk) reset = 1'b1;

        // Random async reset pulses against the arithmetic reference.
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            reset = ($urandom_range(0, 15) != 0);
            #1;
            check_all("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/down_counter.md
# down_counter

Free-running, parameterised binary down counter with asynchronous active-low reset. On every rising clock edge after reset release it decrements by one, then reloads from a configurable top value after reaching zero. It serves as a basic timing/sequencing primitive: a countdown source for downstream logic, with status flags for terminal count and reload. The default configuration is a 4-bit counter that cycles 15 → 0.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 1 to 32.
- TOP_VALUE, 2^WIDTH−1 (15 at default width), value loaded at reset and on wrap; must satisfy 0 < TOP_VALUE ≤ 2^WIDTH−1.

Ports:
- clk  input  1  single clock; all state changes occur on its rising edge, except reset.
- reset  input  1  asynchronous, active-low reset.
- counter  output  WIDTH  current count, driven directly from a register.
- zero  output  1  high while counter == 0; combinational decode of the counter register.
- wrap  output  1  registered one-cycle pulse, high in the cycle immediately after counter reloads from 0 to TOP_VALUE.

## Operation
- Reset (reset == 0) takes effect immediately, with no dependence on clk:
  - counter = TOP_VALUE
  - wrap = 0
  - zero = 0 (counter is nonzero because TOP_VALUE > 0)
- While reset is low, all outputs are held at their reset values regardless of clk activity.
- Each rising clk edge with reset == 1:
  - counter ≠ 0: counter ← counter − 1; wrap ← 0.
  - counter == 0: counter ← TOP_VALUE; wrap ← 1.
- Arithmetic is unsigned and modulo 2^WIDTH. The decrement never underflows, because the value 0 is always replaced by TOP_VALUE instead of wrapping to all-ones. These two values differ only when TOP_VALUE < 2^WIDTH−1.
- Count sequence is TOP_VALUE, TOP_VALUE−1, …, 1, 0, then repeats. Period is TOP_VALUE+1 clocks.
- The counter has no enable, no load input and no direction control. It counts continuously whenever reset is high.
- Outputs never take X or undefined values after reset has been asserted once.

## Timing
- Latency: counter updates exactly one rising edge after the clocking event. There is no pipelining.
- zero follows counter in the same cycle, with combinational delay only.
- wrap is high for exactly one clock period. It coincides with counter == TOP_VALUE on the first cycle after each reload.
- Reset assertion is asynchronous: outputs change without waiting for a clock edge.
- Reset deassertion is treated as synchronous by the surrounding system. The first decrement happens on the first rising edge at which reset is sampled high.
- Reset asserted mid-count: the counter returns to TOP_VALUE at once. After release, counting resumes from TOP_VALUE and no wrap pulse is generated.
- Reset asserted while wrap is high: wrap drops to 0 immediately.
- Reset coinciding with a clock edge: reset wins and the edge is ignored.

## Test plan
- Reset hold: clk running at a 10-unit period, reset = 0 for 20 units → counter = 15, zero = 0, wrap = 0 throughout.
- Count-down after release: release reset at t = 20, then sample after each rising edge → counter = 14, 13, …, 1, 0. zero is high only at 0, and the count reaches 0 after 15 edges.
- Wrap: the edge after counter == 0 → counter = 15 and wrap = 1 for exactly one cycle. Sequence period measured as 16 clocks, across at least 3 full periods.
- Mid-count async reset: pull reset low between clock edges when counter = 7 → counter = 15 before the next edge. After release, the next edge gives 14 and wrap stays 0.
- Non-default parameters: WIDTH = 4, TOP_VALUE = 9 → sequence 9 down to 0, then 9 again. The counter never shows 15, and wrap pulses every 10 clocks.
- Width scaling: WIDTH = 8 with default TOP_VALUE → reset value 255, count reaches 0 after 255 edges, and wrap fires on the 256th edge.
